// File: rtl/instr_pkg.sv
// Shared definitions for the RV32 instruction encoder: format codes,
// the NOP word, immediate range limits and the buffered word layout.
package instr_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } instr_fmt_e;

  // addi x0, x0, 0 -- emitted in place of an unencodable format
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Signed immediate limits; B and J limits are the largest even offsets
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -1048576;
  localparam int IMM21_MAX = 1048574;

  localparam int FIFO_DEPTH = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } enc_word_t;

  // True when the 32-bit two's-complement value lies within [lo, hi]
  function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer and immediate range checker.
module instr_pack
  import instr_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  instr_fmt_e fmt_e;
  assign fmt_e = instr_fmt_e'(fmt);

  // Pack per format; out-of-range immediates still produce the truncated encoding
  always_comb begin
    instr = NOP_INSTR;
    err   = 1'b1;
    case (fmt_e)
      FMT_R: begin
        instr = {funct7, rs2, rs1, funct3, rd, opcode};
        err   = 1'b0;
      end
      FMT_I: begin
        instr = {imm[11:0], rs1, funct3, rd, opcode};
        err   = !in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_S: begin
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err   = !in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_B: begin
        instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err   = !in_range(imm, IMM13_MIN, IMM13_MAX) || imm[0];
      end
      FMT_U: begin
        instr = {imm[31:12], rd, opcode};
        err   = (imm[11:0] != 12'd0);
      end
      FMT_J: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err   = !in_range(imm, IMM21_MIN, IMM21_MAX) || imm[0];
      end
      default: begin
        instr = NOP_INSTR;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// RV32 instruction encoder: packs field sets into words, tags each with a
// running word address and buffers them in a 2-entry FIFO.
module instruction_encoder
  import instr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  input  logic        addr_load,
  input  logic [31:0] addr_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic        error_seen
);

  enc_word_t   fifo_mem_reg [FIFO_DEPTH];
  logic        wr_ptr_reg, wr_ptr_next;
  logic        rd_ptr_reg, rd_ptr_next;
  logic [1:0]  count_reg, count_next;
  logic [31:0] addr_reg, addr_next;
  logic        error_seen_reg, error_seen_next;

  logic [31:0] pack_instr;
  logic        pack_err;
  logic        push, pop;
  logic [31:0] loaded_addr;
  logic [31:0] word_addr;
  enc_word_t   new_word;
  enc_word_t   head_word;
  logic        unused_addr_lsb;

  instr_pack u_pack (
    .fmt    (fmt),
    .opcode (opcode),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .funct3 (funct3),
    .funct7 (funct7),
    .imm    (imm),
    .instr  (pack_instr),
    .err    (pack_err)
  );

  // The low address bits are forced to zero, so only [31:2] is used
  assign unused_addr_lsb = ^addr_value[1:0];

  // Readiness depends only on buffer occupancy and reset, never on in_valid
  assign in_ready    = rst_n && (count_reg < 2'(FIFO_DEPTH));
  assign out_valid   = rst_n && (count_reg != 2'd0);
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign loaded_addr = {addr_value[31:2], 2'b00};
  // A load coincident with acceptance tags this very word with the loaded address
  assign word_addr   = addr_load ? loaded_addr : addr_reg;
  assign new_word    = '{instr: pack_instr, addr: word_addr, err: pack_err};
  assign head_word   = fifo_mem_reg[rd_ptr_reg];

  assign out_instr  = out_valid ? head_word.instr : 32'd0;
  assign out_addr   = out_valid ? head_word.addr  : 32'd0;
  assign out_err    = out_valid ? head_word.err   : 1'b0;
  assign error_seen = rst_n && error_seen_reg;

  // Next-state for pointers, occupancy, address counter and sticky error
  always_comb begin
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    count_next      = count_reg;
    addr_next       = addr_reg;
    error_seen_next = error_seen_reg;
    if (push) begin
      wr_ptr_next = ~wr_ptr_reg;
      addr_next   = word_addr + 32'd4;
      if (pack_err) begin
        error_seen_next = 1'b1;
      end
    end else if (addr_load) begin
      addr_next = loaded_addr;
    end
    if (pop) begin
      rd_ptr_next = ~rd_ptr_reg;
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // Control state register with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg     <= 1'b0;
      rd_ptr_reg     <= 1'b0;
      count_reg      <= 2'd0;
      addr_reg       <= 32'd0;
      error_seen_reg <= 1'b0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      addr_reg       <= addr_next;
      error_seen_reg <= error_seen_next;
    end
  end

  // One storage slot per FIFO entry, written when the write pointer selects it
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        fifo_mem_reg[gi] <= '0;
      end else if (push && (wr_ptr_reg == 1'(gi))) begin
        fifo_mem_reg[gi] <= new_word;
      end
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench: directed literal checks plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        addr_load;
  logic [31:0] addr_value;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic        error_seen;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  instruction_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fmt        (fmt),
    .opcode     (opcode),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .funct3     (funct3),
    .funct7     (funct7),
    .imm        (imm),
    .addr_load  (addr_load),
    .addr_value (addr_value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_addr   (out_addr),
    .out_err    (out_err),
    .error_seen (error_seen)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } mw_t;

  mw_t         q[$];
  logic [31:0] m_addr = 32'd0;
  bit          m_err_seen = 1'b0;

  // Encoding straight from the format table; range checks in integer arithmetic
  function automatic mw_t ref_encode(input logic [2:0] f, input logic [6:0] op,
                                     input logic [4:0] d, input logic [4:0] s1,
                                     input logic [4:0] s2, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [31:0] im);
    mw_t w;
    int  v;
    v = im;
    w.addr = 32'd0;
    case (f)
      3'd0: begin w.instr = {f7, s2, s1, f3, d, op}; w.err = 1'b0; end
      3'd1: begin w.instr = {im[11:0], s1, f3, d, op}; w.err = (v < -2048) || (v > 2047); end
      3'd2: begin w.instr = {im[11:5], s2, s1, f3, im[4:0], op}; w.err = (v < -2048) || (v > 2047); end
      3'd3: begin
        w.instr = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
        w.err   = (v < -4096) || (v > 4094) || (v % 2 != 0);
      end
      3'd4: begin w.instr = {im[31:12], d, op}; w.err = (v % 4096 != 0); end
      3'd5: begin
        w.instr = {im[20], im[10:1], im[11], im[19:12], d, op};
        w.err   = (v < -1048576) || (v > 1048574) || (v % 2 != 0);
      end
      default: begin w.instr = 32'h0000_0013; w.err = 1'b1; end
    endcase
    return w;
  endfunction

  // Model update on each rising edge from the same inputs the DUT samples
  always @(posedge clk) begin
    bit  acc, pop;
    mw_t w;
    if (!rst_n) begin
      q.delete();
      m_addr     = 32'd0;
      m_err_seen = 1'b0;
    end else begin
      acc = in_valid && (q.size() < 2);
      pop = (q.size() > 0) && out_ready;
      if (pop) void'(q.pop_front());
      if (acc) begin
        w = ref_encode(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
        w.addr = addr_load ? {addr_value[31:2], 2'b00} : m_addr;
        m_addr = w.addr + 32'd4;
        if (w.err) m_err_seen = 1'b1;
        q.push_back(w);
        $display("accept fmt=%0d imm=0x%08h addr=0x%08h instr=0x%08h err=%0d",
                 fmt, imm, w.addr, w.instr, w.err);
      end else if (addr_load) begin
        m_addr = {addr_value[31:2], 2'b00};
      end
    end
  end

  // Compare on every falling edge
  always @(negedge clk) begin
    if (started) begin
      chk("m_in_ready", in_ready, 32'(rst_n && (q.size() < 2)));
      chk("m_out_valid", out_valid, 32'(rst_n && (q.size() > 0)));
      chk("m_error_seen", error_seen, 32'(rst_n && m_err_seen));
      if (rst_n && (q.size() > 0)) begin
        chk("m_out_instr", out_instr, q[0].instr);
        chk("m_out_addr", out_addr, q[0].addr);
        chk("m_out_err", out_err, 32'(q[0].err));
      end else if (!rst_n) begin
        chk("m_rst_instr", out_instr, 32'd0);
        chk("m_rst_addr", out_addr, 32'd0);
        chk("m_rst_err", out_err, 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_word(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                          input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [31:0] imm_pool [14] = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094,
                                 32'd4095, 32'd4096, -32'sd4096, -32'sd4098, 32'd1048574,
                                 32'd1048576, -32'sd1048576, -32'sd1048578, 32'h1234_5000};

  function automatic logic [31:0] rand_imm();
    int sel;
    sel = $urandom_range(0, 3);
    case (sel)
      0:       return imm_pool[$urandom_range(0, 13)];
      1:       return 32'($urandom_range(0, 4095)) - 32'd2048;
      2:       return {$urandom_range(0, 32'hFFFFF), 12'd0};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; addr_load = 1'b0; addr_value = 32'd0;
    set_word(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b0;
    tick();
    started = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_in_ready", in_ready, 32'd0);
    chk("rst_error_seen", error_seen, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", in_ready, 32'd1);

    // R-type add x3, x1, x2
    set_word(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    chk("r_valid", out_valid, 32'd1);
    chk("r_instr", out_instr, 32'h0020_81B3);
    chk("r_addr", out_addr, 32'd0);
    chk("r_err", out_err, 32'd0);

    // I-type addi x1, x0, -1 then out-of-range immediate
    set_word(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    chk("i_instr", out_instr, 32'hFFF0_0093);
    chk("i_err", out_err, 32'd0);
    chk("i_addr", out_addr, 32'd4);
    set_word(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    chk("i2048_err", out_err, 32'd1);
    chk("i2048_error_seen", error_seen, 32'd1);

    // B-type beq x1, x2, +8 then odd offset
    set_word(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    chk("b_instr", out_instr, 32'h0020_8463);
    chk("b_err", out_err, 32'd0);
    set_word(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    chk("b_odd_err", out_err, 32'd1);

    // Illegal format yields NOP with error
    set_word(3'd6, 7'h7F, 5'd9, 5'd9, 5'd9, 3'd7, 7'h7F, 32'd0);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    chk("illegal_instr", out_instr, 32'h0000_0013);
    chk("illegal_err", out_err, 32'd1);

    // Back-pressure: three offered, two accepted, order and stability
    do_reset();
    out_ready = 1'b0;
    set_word(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    tick();
    set_word(3'd0, 7'h33, 5'd4, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    tick();
    set_word(3'd0, 7'h33, 5'd5, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    tick();
    @(negedge clk);
    chk("stall_in_ready", in_ready, 32'd0);
    chk("stall_addr0", out_addr, 32'd0);
    tick();
    @(negedge clk);
    chk("stall_hold_addr", out_addr, 32'd0);
    chk("stall_hold_instr", out_instr, 32'h0020_81B3);
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("drain_addr4", out_addr, 32'd4);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    chk("drain_addr8", out_addr, 32'd8);

    // Address load coincident with acceptance, then wrap
    do_reset();
    addr_load = 1'b1; addr_value = 32'hFFFF_FFFE;
    set_word(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    tick();
    addr_load = 1'b0;
    set_word(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    @(negedge clk);
    chk("load_addr", out_addr, 32'hFFFF_FFFC);
    chk("u_instr", out_instr, 32'h1234_50B7);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    chk("wrap_addr", out_addr, 32'd0);

    // Reset with a full FIFO and sticky error set
    tick();
    out_ready = 1'b0;
    set_word(3'd7, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    tick();
    tick(); in_valid = 1'b0;
    @(negedge clk);
    chk("full_in_ready", in_ready, 32'd0);
    chk("full_error_seen", error_seen, 32'd1);
    do_reset();
    @(negedge clk);
    chk("post_rst_valid", out_valid, 32'd0);
    chk("post_rst_error_seen", error_seen, 32'd0);
    out_ready = 1'b1;
    set_word(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_addr", out_addr, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      tick();
      rst_n      = ($urandom_range(0, 99) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      addr_load  = ($urandom_range(0, 9) == 0);
      addr_value = $urandom;
      set_word(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
               5'($urandom), 3'($urandom), 7'($urandom), rand_imm());
      in_valid   = ($urandom_range(0, 3) != 0);
    end
    tick();
    rst_n = 1'b1; in_valid = 1'b0; addr_load = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    started = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: in_valid  in  1  field set offered; in_ready  out  1  block can accept.
REQ-004 SHALL have ports: fmt  in  3  format code, R=0, I=1, S=2, B=3, U=4, J=5, 6-7 illegal.
REQ-005 SHALL have ports: opcode in 7; rd in 5; rs1 in 5; rs2 in 5; funct3 in 3; funct7 in 7  RV32 fields.
REQ-006 SHALL have ports: imm  in  32  signed immediate, byte offset for B/J, full value for U.
REQ-007 SHALL have ports: addr_load  in  1  load pulse; addr_value  in  32  new word address.
REQ-008 SHALL have ports: out_valid out 1; out_ready in 1; out_instr out 32; out_addr out 32; out_err out 1.
REQ-009 SHALL have ports: error_seen  out  1  sticky, any word emitted with out_err=1.

Function
REQ-010 SHALL accept a field set when in_valid and in_ready are both 1 on a rising edge.
REQ-011 SHALL drive in_ready=1 when the output buffer holds fewer than 2 words; it SHALL NOT depend combinationally on in_valid.
REQ-012 SHALL present an accepted word on out_valid one cycle after acceptance when the buffer was empty.
REQ-013 SHALL sustain one word per cycle throughput when out_ready=1.
REQ-014 SHALL hold out_instr, out_addr and out_err stable while out_valid=1 and out_ready=0.
REQ-015 SHALL emit words in acceptance order through a 2-entry FIFO. Simultaneous push and pop when full SHALL NOT be accepted, because in_ready=0.
REQ-016 SHALL pack fields as follows:
- R: funct7|rs2|rs1|funct3|rd|opcode.
- I: imm[11:0]|rs1|funct3|rd|opcode.
- S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
- B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
- U: imm[31:12]|rd|opcode.
- J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
REQ-017 SHALL set out_err=1 for any of these conditions:
- I/S imm outside [-2048, 2047].
- B imm outside [-4096, 4094] or imm[0]=1.
- J imm outside [-1048576, 1048574] or imm[0]=1.
- U imm[11:0] nonzero.
REQ-018 SHALL still emit the truncated packing when out_err=1 for a legal fmt.
REQ-019 SHALL emit NOP 0x00000013 with out_err=1 for illegal fmt 6 or 7.
REQ-020 SHALL maintain a 32-bit address counter, reset to 0, that increments by 4 per accepted word; each word carries its address on out_addr.
REQ-021 SHALL wrap the address counter from 0xFFFFFFFC to 0x00000000.
REQ-022 SHALL, on addr_load=1, set the counter to {addr_value[31:2], 2'b00}.
REQ-023 SHALL, on addr_load coincident with an acceptance, tag that word with the loaded address and set the counter to loaded+4.
REQ-024 SHALL set error_seen on the cycle a word with out_err=1 is accepted; only reset clears it.

Reset
REQ-025 SHALL, on any rising edge with rst_n=0, clear the FIFO, the address counter and error_seen, discarding any buffered words.
REQ-026 SHALL drive out_valid=0, out_instr=0, out_addr=0, out_err=0 and error_seen=0 during reset.
REQ-027 SHALL drive in_ready=0 while rst_n=0 and in_ready=1 on the first cycle after release.

Structure
REQ-028 SHALL take the format enum (instr_fmt_e), the NOP constant and the immediate range limits from shared package instr_pkg.
REQ-029 SHALL place packing and range checking in combinational sub-module instr_pack; FIFO, handshake and address counter SHALL reside in the top module.

Verification
REQ-030 SHALL verify: R, op=0x33, rd=3, rs1=1, rs2=2, f3=0, f7=0, out_ready=1 -> out_instr=0x002081B3, out_addr=0, out_err=0, one cycle later.
REQ-031 SHALL verify: I, op=0x13, rd=1, rs1=0, imm=0xFFFFFFFF -> 0xFFF00093, out_err=0; then I, imm=2048 -> out_err=1, error_seen=1.
REQ-032 SHALL verify: B, op=0x63, rs1=1, rs2=2, f3=0, imm=8 -> 0x00208463; then imm=7 -> out_err=1.
REQ-033 SHALL verify: out_ready=0 with 3 words offered -> 2 accepted and in_ready=0. On out_ready=1 -> words in order with out_addr 0, 4, 8; out_* stable while stalled.
REQ-034 SHALL verify: addr_load with addr_value=0xFFFFFFFE coincident with the first acceptance, then one more word -> out_addr 0xFFFFFFFC, then 0x00000000.
REQ-035 SHALL verify: FIFO holding 2 words and error_seen=1, rst_n=0 for one edge -> out_valid=0, error_seen=0, next word's out_addr=0.
